// File: rtl/elastic_buf.sv
// elastic_buf -- DEPTH-entry valid/ready elastic buffer.
//
// Decouples two pipeline stages: in_ready is a registered function of the
// buffer's own occupancy, so there is no combinational path from out_ready
// back to in_ready. Bursts of downstream back-pressure are absorbed in a
// circular array of DEPTH entries without dropping or duplicating beats.
//
// Parameters:
//   WIDTH          payload width in bits (>=1)
//   DEPTH          number of storage entries (>=2, any value, not only 2^n)
//   MAYBE_UNKNOWN  1 = payload may carry X; disables the X-check assertion
//
// Ports:
//   clk        clock, all state updates on posedge
//   rst_n      asynchronous active-low reset
//   in_valid   upstream beat present
//   in_ready   buffer can accept a beat (registered, == !full)
//   in_data    upstream payload
//   out_valid  head entry (or bypass beat) present
//   out_ready  downstream accepts the head
//   out_data   head payload, don't-care when !out_valid
//   count      occupancy 0..DEPTH
//   full       count == DEPTH
//   empty      count == 0
//
// Optional feature macro: ELASTIC_BUF_BYPASS_EN
//   When defined, a beat arriving while the buffer is empty is presented on
//   the output in the same cycle; if it is taken immediately it never touches
//   the array. When undefined there is no in->out combinational path.

module elastic_buf #(
  parameter int WIDTH         = 32,
  parameter int DEPTH         = 2,
  parameter int MAYBE_UNKNOWN = 0,
  localparam int CW           = $clog2(DEPTH + 1),
  localparam int PW           = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count_nxt;
  logic             push;
  logic             pop;
  logic             pass;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    ptr_inc = (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

`ifdef ELASTIC_BUF_BYPASS_EN
  // An empty buffer forwards the incoming beat directly; if it is popped in
  // the same cycle it bypasses the array and occupancy stays at zero.
  assign out_valid = !empty || in_valid;
  assign out_data  = empty ? in_data : mem[rd_ptr];
  assign pass      = empty && in_valid && out_ready;
`else
  assign out_valid = !empty;
  assign out_data  = mem[rd_ptr];
  assign pass      = 1'b0;
`endif

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // Simultaneous push and pop leaves occupancy unchanged (this also covers
  // a bypassed beat).
  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + 1'b1;
    else if (pop && !push) count_nxt = count - 1'b1;
  end

  // Control state: pointers, occupancy and registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      in_ready <= 1'b1;
    end else begin
      if (push && !pass) wr_ptr <= ptr_inc(wr_ptr);
      if (pop && !pass)  rd_ptr <= ptr_inc(rd_ptr);
      count    <= count_nxt;
      empty    <= (count_nxt == '0);
      full     <= (count_nxt == CW'(DEPTH));
      in_ready <= (count_nxt != CW'(DEPTH));
    end
  end

  // Payload storage; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (push && !pass) mem[wr_ptr] <= in_data;
  end

`ifndef SYNTHESIS
  int ptr_dist;

  always_comb begin
    ptr_dist = (int'(wr_ptr) - int'(rd_ptr) + DEPTH) % DEPTH;
  end

  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && full));

`ifdef ELASTIC_BUF_BYPASS_EN
  a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && empty && !in_valid));
`else
  a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && empty));
`endif

  a_count_dist: assert property (@(posedge clk) disable iff (!rst_n)
    (count == CW'(DEPTH)) ? (wr_ptr == rd_ptr) : (int'(count) == ptr_dist));

  generate
    if (MAYBE_UNKNOWN == 0) begin : g_xchk
      a_data_known: assert property (@(posedge clk) disable iff (!rst_n)
        out_valid |-> !$isunknown(out_data));
    end
  endgenerate
`endif

endmodule

// File: tb/tb_elastic_buf.sv
// tb_elastic_buf -- directed bench for elastic_buf (WIDTH=8, DEPTH=3).
// Inputs change 1 time unit after posedge; handshakes are observed on negedge.

module tb_elastic_buf;

  localparam int WIDTH = 8;
  localparam int DEPTH = 3;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;

  int errors = 0;
  int checks = 0;

  logic [WIDTH-1:0] rx[$];

  elastic_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MAYBE_UNKNOWN(0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Record every beat accepted downstream (pop occurs at the next posedge).
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) rx.push_back(out_data);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int guard;
    logic acc;
    int max_cnt;
    int rdy_drops;
    int stale;

    rst_n = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_count",     32'(count),     32'd0);
    check("rst_empty",     32'(empty),     32'd1);
    check("rst_full",      32'(full),      32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    @(negedge clk); rst_n = 1'b1;
    step();

    // 1: single beat 0xA5 with downstream ready
    in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
    #1;
`ifdef ELASTIC_BUF_BYPASS_EN
    check("t1_bypass_valid", 32'(out_valid), 32'd1);
    check("t1_bypass_data",  32'(out_data),  32'hA5);
`else
    check("t1_no_same_cycle", 32'(out_valid), 32'd0);
`endif
    step();
    in_valid = 1'b0;
    #1;
`ifdef ELASTIC_BUF_BYPASS_EN
    check("t1_count", 32'(count), 32'd0);
    check("t1_valid", 32'(out_valid), 32'd0);
`else
    check("t1_count", 32'(count), 32'd1);
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_data",  32'(out_data),  32'hA5);
`endif
    step();
    check("t1_count_back", 32'(count), 32'd0);
    check("t1_empty_back", 32'(empty), 32'd1);

    // 2: fill with out_ready low, 4th beat held
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h01; step();
    in_data = 8'h02; step();
    in_data = 8'h03; step();
    check("t2_count",    32'(count),    32'd3);
    check("t2_full",     32'(full),     32'd1);
    check("t2_in_ready", 32'(in_ready), 32'd0);
    in_data = 8'h04; step();
    check("t2_held_count", 32'(count),    32'd3);
    check("t2_head",       32'(out_data), 32'h01);

    // 3: full, pop one with in_valid still high
    out_ready = 1'b1;
    #1;
    check("t3_pop_data", 32'(out_data), 32'h01);
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    check("t3_count",    32'(count),    32'd2);
    check("t3_in_ready", 32'(in_ready), 32'd1);
    check("t3_full",     32'(full),     32'd0);
    check("t3_head",     32'(out_data), 32'h02);
    out_ready = 1'b1;
    step();
    check("t3_head2", 32'(out_data), 32'h03);
    step();
    check("t3_drained", 32'(count), 32'd0);

    // 4: 10 beats with random out_ready, order preserved
    rx.delete();
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h10 + i);
      guard = 0;
      do begin
        acc = in_ready;
        out_ready = 1'($urandom_range(0, 1));
        step();
        guard++;
      end while (!acc && guard < 50);
      if (!acc) check("t4_push_timeout", 32'(guard), 32'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    guard = 0;
    while (!empty && guard < 10) begin step(); guard++; end
    check("t4_drain_empty", 32'(empty), 32'd1);
    check("t4_rx_count", 32'(rx.size()), 32'd10);
    for (int i = 0; i < 10; i++) begin
      if (i < rx.size()) check($sformatf("t4_beat%0d", i), 32'(rx[i]), 32'(8'h10 + i));
    end

    // 5: reset mid-stream with two beats stored
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h55; step();
    in_data = 8'h66; step();
    in_valid = 1'b0;
    check("t5_count_pre", 32'(count), 32'd2);
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid",    32'(out_valid), 32'd0);
    check("t5_rst_count",    32'(count),     32'd0);
    check("t5_rst_in_ready", 32'(in_ready),  32'd1);
    @(negedge clk); rst_n = 1'b1;
    rx.delete();
    out_ready = 1'b1;
    stale = 0;
    repeat (4) begin
      step();
      if (out_valid) stale++;
    end
    check("t5_stale_valid", 32'(stale), 32'd0);
    check("t5_stale_rx", 32'(rx.size()), 32'd0);

    // 6: 20 cycles of continuous flow
    rx.delete();
    max_cnt = 0; rdy_drops = 0;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_data = 8'(8'h80 + i);
      if (!in_ready) rdy_drops++;
      step();
      if (int'(count) > max_cnt) max_cnt = int'(count);
    end
    in_valid = 1'b0;
    step(); step();
`ifdef ELASTIC_BUF_BYPASS_EN
    check("t6_max_count", 32'(max_cnt), 32'd0);
`else
    check("t6_max_count", 32'(max_cnt), 32'd1);
`endif
    check("t6_ready_drops", 32'(rdy_drops), 32'd0);
    check("t6_delivered", 32'(rx.size()), 32'd20);
    for (int i = 0; i < 20; i += 7) begin
      if (i < rx.size()) check($sformatf("t6_beat%0d", i), 32'(rx[i]), 32'(8'h80 + i));
    end
    check("t6_empty_end", 32'(empty), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
